// File: rtl/axil_regs_responder.sv
// AXI4-lite register endpoint: REG_COUNT read/write control registers followed
// by STAT_COUNT read-only status words in a flat word-indexed map.
// Optional build macro AXIL_REGS_PROT_CHECK_EN: when defined, unprivileged
// accesses (prot[0]==0) to mapped words are refused with SLVERR.
module axil_regs_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int REG_COUNT  = 8,
  parameter int STAT_COUNT = 4,
  parameter logic [REG_COUNT*DATA_WIDTH-1:0] CTRL_RESET_VAL = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            s_axil_awaddr,
  input  logic [2:0]                       s_axil_awprot,
  input  logic                             s_axil_awvalid,
  output logic                             s_axil_awready,
  input  logic [DATA_WIDTH-1:0]            s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]            s_axil_wstrb,
  input  logic                             s_axil_wvalid,
  output logic                             s_axil_wready,
  output logic [1:0]                       s_axil_bresp,
  output logic                             s_axil_bvalid,
  input  logic                             s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]            s_axil_araddr,
  input  logic [2:0]                       s_axil_arprot,
  input  logic                             s_axil_arvalid,
  output logic                             s_axil_arready,
  output logic [DATA_WIDTH-1:0]            s_axil_rdata,
  output logic [1:0]                       s_axil_rresp,
  output logic                             s_axil_rvalid,
  input  logic                             s_axil_rready,
  output logic [REG_COUNT*DATA_WIDTH-1:0]  ctrl_regs,
  output logic [REG_COUNT-1:0]             ctrl_wr_pulse,
  input  logic [STAT_COUNT*DATA_WIDTH-1:0] stat_regs,
  output logic [STAT_COUNT-1:0]            stat_rd_pulse
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

  typedef logic [IDX_W:0] idx_t;

  localparam idx_t CTRL_END = idx_t'(REG_COUNT);
  localparam idx_t STAT_END = idx_t'(REG_COUNT + STAT_COUNT);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    REGION_CTRL,
    REGION_STAT,
    REGION_NONE
  } region_e;

  function automatic region_e decodeRegion(input idx_t idx);
    if (idx < CTRL_END) begin
      return REGION_CTRL;
    end else if (idx < STAT_END) begin
      return REGION_STAT;
    end
    return REGION_NONE;
  endfunction

  // Write-side holding registers and response state
  logic                            awHeld_q, awHeld_d;
  logic [IDX_W-1:0]                awIdx_q, awIdx_d;
  logic [2:0]                      awProt_q, awProt_d;
  logic                            wHeld_q, wHeld_d;
  logic [DATA_WIDTH-1:0]           wData_q, wData_d;
  logic [STRB_WIDTH-1:0]           wStrb_q, wStrb_d;
  logic                            bvalid_q, bvalid_d;
  logic [1:0]                      bresp_q, bresp_d;
  logic [REG_COUNT*DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [REG_COUNT-1:0]            ctrlPulse_q, ctrlPulse_d;

  // Read-side response state
  logic                            rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]           rdata_q, rdata_d;
  logic [1:0]                      rresp_q, rresp_d;
  logic [STAT_COUNT-1:0]           statPulse_q, statPulse_d;

  logic    commit;
  logic    arReady;
  logic    awPriv;
  logic    arPriv;
  idx_t    awIdxExt;
  idx_t    arIdxExt;
  region_e awRegion;
  region_e arRegion;
  logic    unusedBits;

`ifdef AXIL_REGS_PROT_CHECK_EN
  assign awPriv = awProt_q[0];
  assign arPriv = s_axil_arprot[0];
`else
  assign awPriv = 1'b1;
  assign arPriv = 1'b1;
`endif

  assign unusedBits = ^{awProt_q, s_axil_arprot,
                        s_axil_awaddr[ADDR_LSB-1:0], s_axil_araddr[ADDR_LSB-1:0]};

  assign awIdxExt = idx_t'(awIdx_q);
  assign arIdxExt = idx_t'(s_axil_araddr[ADDR_WIDTH-1:ADDR_LSB]);
  assign awRegion = decodeRegion(awIdxExt);
  assign arRegion = decodeRegion(arIdxExt);

  // A write commits once both halves are held and the B slot is free or draining
  assign commit  = awHeld_q && wHeld_q && (!bvalid_q || s_axil_bready);
  assign arReady = !rvalid_q || s_axil_rready;

  // Write path: capture AW/W independently, commit and build the B response
  always_comb begin
    awHeld_d    = awHeld_q;
    awIdx_d     = awIdx_q;
    awProt_d    = awProt_q;
    wHeld_d     = wHeld_q;
    wData_d     = wData_q;
    wStrb_d     = wStrb_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    ctrl_d      = ctrl_q;
    ctrlPulse_d = '0;
    if (bvalid_q && s_axil_bready) begin
      bvalid_d = 1'b0;
    end
    if (s_axil_awvalid && !awHeld_q) begin
      awHeld_d = 1'b1;
      awIdx_d  = s_axil_awaddr[ADDR_WIDTH-1:ADDR_LSB];
      awProt_d = s_axil_awprot;
    end
    if (s_axil_wvalid && !wHeld_q) begin
      wHeld_d = 1'b1;
      wData_d = s_axil_wdata;
      wStrb_d = s_axil_wstrb;
    end
    if (commit) begin
      awHeld_d = 1'b0;
      wHeld_d  = 1'b0;
      bvalid_d = 1'b1;
      unique case (awRegion)
        REGION_CTRL: begin
          if (awPriv) begin
            bresp_d = RESP_OKAY;
            for (int i = 0; i < REG_COUNT; i++) begin
              if (idx_t'(i) == awIdxExt) begin
                for (int b = 0; b < STRB_WIDTH; b++) begin
                  if (wStrb_q[b]) begin
                    ctrl_d[i*DATA_WIDTH + b*8 +: 8] = wData_q[b*8 +: 8];
                  end
                end
                ctrlPulse_d[i] = 1'b1;
              end
            end
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end
        REGION_STAT: bresp_d = RESP_SLVERR;
        default:     bresp_d = RESP_DECERR;
      endcase
    end
  end

  // Read path: decode on AR handshake and register the R response
  always_comb begin
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    statPulse_d = '0;
    if (rvalid_q && s_axil_rready) begin
      rvalid_d = 1'b0;
    end
    if (s_axil_arvalid && arReady) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
      unique case (arRegion)
        REGION_CTRL: begin
          if (arPriv) begin
            for (int i = 0; i < REG_COUNT; i++) begin
              if (idx_t'(i) == arIdxExt) begin
                rdata_d = ctrl_q[i*DATA_WIDTH +: DATA_WIDTH];
              end
            end
          end else begin
            rresp_d = RESP_SLVERR;
          end
        end
        REGION_STAT: begin
          if (arPriv) begin
            for (int j = 0; j < STAT_COUNT; j++) begin
              if (idx_t'(REG_COUNT + j) == arIdxExt) begin
                rdata_d        = stat_regs[j*DATA_WIDTH +: DATA_WIDTH];
                statPulse_d[j] = 1'b1;
              end
            end
          end else begin
            rresp_d = RESP_SLVERR;
          end
        end
        default: rresp_d = RESP_DECERR;
      endcase
    end
  end

  // State registers; reset drops any in-flight request or pending response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awHeld_q    <= 1'b0;
      awIdx_q     <= '0;
      awProt_q    <= '0;
      wHeld_q     <= 1'b0;
      wData_q     <= '0;
      wStrb_q     <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      ctrl_q      <= CTRL_RESET_VAL;
      ctrlPulse_q <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= 2'b00;
      statPulse_q <= '0;
    end else begin
      awHeld_q    <= awHeld_d;
      awIdx_q     <= awIdx_d;
      awProt_q    <= awProt_d;
      wHeld_q     <= wHeld_d;
      wData_q     <= wData_d;
      wStrb_q     <= wStrb_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      ctrl_q      <= ctrl_d;
      ctrlPulse_q <= ctrlPulse_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      statPulse_q <= statPulse_d;
    end
  end

  assign s_axil_awready = !awHeld_q;
  assign s_axil_wready  = !wHeld_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arReady;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign ctrl_regs      = ctrl_q;
  assign ctrl_wr_pulse  = ctrlPulse_q;
  assign stat_rd_pulse  = statPulse_q;

endmodule

// File: tb/tb_axil_regs_responder.sv
// Self-checking bench for axil_regs_responder: directed scenarios plus random
// single transactions, all compared against a word-level register map model.
module tb_axil_regs_responder;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int RC = 8;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0]    awaddr;
  logic [2:0]       awprot;
  logic             awvalid, awready;
  logic [DW-1:0]    wdata;
  logic [DW/8-1:0]  wstrb;
  logic             wvalid, wready;
  logic [1:0]       bresp;
  logic             bvalid, bready;
  logic [AW-1:0]    araddr;
  logic [2:0]       arprot;
  logic             arvalid, arready;
  logic [DW-1:0]    rdata;
  logic [1:0]       rresp;
  logic             rvalid, rready;
  logic [RC*DW-1:0] ctrlRegs;
  logic [RC-1:0]    ctrlWrPulse;
  logic [SC*DW-1:0] statRegs;
  logic [SC-1:0]    statRdPulse;

  logic [31:0] ctrlModel [RC];
  logic [31:0] statModel [SC];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign statRegs = {statModel[3], statModel[2], statModel[1], statModel[0]};

  axil_regs_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC), .STAT_COUNT(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
    .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid),
    .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
    .s_axil_rready(rready),
    .ctrl_regs(ctrlRegs), .ctrl_wr_pulse(ctrlWrPulse),
    .stat_regs(statRegs), .stat_rd_pulse(statRdPulse)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [RC*DW-1:0] packCtrl();
    logic [RC*DW-1:0] v;
    for (int i = 0; i < RC; i++) v[i*DW +: DW] = ctrlModel[i];
    return v;
  endfunction

  function automatic int wordIndex(input logic [AW-1:0] addr);
    return int'(addr) / 4;
  endfunction

  function automatic logic privOk(input logic [2:0] prot);
`ifdef AXIL_REGS_PROT_CHECK_EN
    return prot[0];
`else
    return 1'b1;
`endif
  endfunction

  // Reference effect of one committed write on the register map
  task automatic modelWrite(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [2:0] prot,
                            output logic [1:0] resp, output logic [RC-1:0] pulse);
    int idx;
    idx   = wordIndex(addr);
    pulse = '0;
    if (idx >= RC + SC) resp = 2'b11;
    else if (idx >= RC || !privOk(prot)) resp = 2'b10;
    else begin
      resp = 2'b00;
      for (int b = 0; b < 4; b++)
        if (strb[b]) ctrlModel[idx][8*b +: 8] = data[8*b +: 8];
      pulse[idx] = 1'b1;
    end
  endtask

  // Reference response for one read given the current map contents
  task automatic modelRead(input logic [AW-1:0] addr, input logic [2:0] prot,
                           output logic [31:0] data, output logic [1:0] resp,
                           output logic [SC-1:0] pulse);
    int idx;
    idx   = wordIndex(addr);
    data  = '0;
    pulse = '0;
    resp  = 2'b00;
    if (idx >= RC + SC) resp = 2'b11;
    else if (!privOk(prot)) resp = 2'b10;
    else if (idx < RC) data = ctrlModel[idx];
    else begin
      data = statModel[idx-RC];
      pulse[idx-RC] = 1'b1;
    end
  endtask

  // AW and W together from idle, bready high; checks exact one-cycle commit
  task automatic doWrite(input logic [AW-1:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [2:0] prot);
    logic [1:0] expResp;
    logic [RC-1:0] expPulse;
    @(negedge clk);
    awaddr = addr; awprot = prot; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    checkOutput("wr_awready", 256'(awready), 256'(1'b1));
    checkOutput("wr_wready", 256'(wready), 256'(1'b1));
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("wr_bvalid_early", 256'(bvalid), 256'(1'b0));
    modelWrite(addr, data, strb, prot, expResp, expPulse);
    @(negedge clk);
    checkOutput("wr_bvalid", 256'(bvalid), 256'(1'b1));
    checkOutput("wr_bresp", 256'(bresp), 256'(expResp));
    checkOutput("wr_ctrl", 256'(ctrlRegs), 256'(packCtrl()));
    checkOutput("wr_pulse", 256'(ctrlWrPulse), 256'(expPulse));
    @(negedge clk);
    checkOutput("wr_bvalid_drop", 256'(bvalid), 256'(1'b0));
    checkOutput("wr_pulse_drop", 256'(ctrlWrPulse), 256'(0));
  endtask

  // Single read from idle with rready high; checks latency-1 response
  task automatic doRead(input logic [AW-1:0] addr, input logic [2:0] prot);
    logic [31:0] expData;
    logic [1:0] expResp;
    logic [SC-1:0] expPulse;
    @(negedge clk);
    araddr = addr; arprot = prot; arvalid = 1'b1; rready = 1'b1;
    modelRead(addr, prot, expData, expResp, expPulse);
    checkOutput("rd_arready", 256'(arready), 256'(1'b1));
    @(negedge clk);
    arvalid = 1'b0;
    checkOutput("rd_rvalid", 256'(rvalid), 256'(1'b1));
    checkOutput("rd_rdata", 256'(rdata), 256'(expData));
    checkOutput("rd_rresp", 256'(rresp), 256'(expResp));
    checkOutput("rd_pulse", 256'(statRdPulse), 256'(expPulse));
    @(negedge clk);
    checkOutput("rd_rvalid_drop", 256'(rvalid), 256'(1'b0));
    checkOutput("rd_pulse_drop", 256'(statRdPulse), 256'(0));
  endtask

  // One random transaction: mostly mapped words, sometimes far unmapped ones
  task automatic applyStimulus();
    int idx;
    logic [AW-1:0] addr;
    logic [2:0] prot;
    idx  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 200)) : int'($urandom_range(0, 11));
    addr = 16'(idx * 4 + int'($urandom_range(0, 3)));
    prot = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) begin
      doWrite(addr, $urandom, 4'($urandom_range(0, 15)), prot);
    end else begin
      statModel[$urandom_range(0, 3)] = $urandom;
      doRead(addr, prot);
    end
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] d1, d2, expData, prevData;
    logic [1:0] r1, r2, expResp, prevResp;
    logic [RC-1:0] p1, p2;
    logic [SC-1:0] sp;

    for (int i = 0; i < RC; i++) ctrlModel[i] = '0;
    for (int j = 0; j < SC; j++) statModel[j] = $urandom;
    rst_n = 1'b0;
    awaddr = '0; awprot = 3'b001; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = 3'b001; arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    checkOutput("rst_awready", 256'(awready), 256'(1'b1));
    checkOutput("rst_wready", 256'(wready), 256'(1'b1));
    checkOutput("rst_arready", 256'(arready), 256'(1'b1));
    checkOutput("rst_bvalid", 256'(bvalid), 256'(1'b0));
    checkOutput("rst_rvalid", 256'(rvalid), 256'(1'b0));
    checkOutput("rst_resps", 256'({bresp, rresp}), 256'(0));
    checkOutput("rst_rdata", 256'(rdata), 256'(0));
    checkOutput("rst_ctrl", 256'(ctrlRegs), 256'(0));
    checkOutput("rst_pulses", 256'({ctrlWrPulse, statRdPulse}), 256'(0));

    // Full-word write to register 1
    doWrite(16'h0004, 32'hDEADBEEF, 4'hF, 3'b001);
    checkOutput("reg1_full", 256'(ctrlRegs[63:32]), 256'(32'hDEADBEEF));

    // W arrives three cycles before AW; nothing commits until AW shows up
    @(negedge clk);
    wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("wfirst_wready", 256'(wready), 256'(1'b0));
      checkOutput("wfirst_bvalid", 256'(bvalid), 256'(1'b0));
      @(negedge clk);
    end
    awaddr = 16'h0004; awprot = 3'b001; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    checkOutput("wfirst_bvalid_early", 256'(bvalid), 256'(1'b0));
    modelWrite(16'h0004, 32'h000000AA, 4'h1, 3'b001, r1, p1);
    @(negedge clk);
    checkOutput("wfirst_bvalid", 256'(bvalid), 256'(1'b1));
    checkOutput("wfirst_bresp", 256'(bresp), 256'(r1));
    checkOutput("wfirst_reg1", 256'(ctrlRegs[63:32]), 256'(32'hDEADBEAA));
    checkOutput("wfirst_pulse", 256'(ctrlWrPulse), 256'(p1));
    @(negedge clk);
    checkOutput("wfirst_bvalid_drop", 256'(bvalid), 256'(1'b0));

    // Status word read, then a refused write to it
    statModel[0] = 32'h12345678;
    doRead(16'h0020, 3'b001);
    doWrite(16'h0020, 32'h55AA55AA, 4'hF, 3'b001);

    // Unmapped word index 64
    doRead(16'h0100, 3'b001);
    doWrite(16'h0100, 32'h01020304, 4'hF, 3'b001);

    // B stall: second AW/W is held until bready, then issues its own response
    d1 = $urandom; d2 = $urandom;
    @(negedge clk);
    awaddr = 16'h000C; awprot = 3'b001; awvalid = 1'b1;
    wdata = d1; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    modelWrite(16'h000C, d1, 4'hF, 3'b001, r1, p1);
    @(negedge clk);
    checkOutput("stall_bvalid1", 256'(bvalid), 256'(1'b1));
    checkOutput("stall_bresp1", 256'(bresp), 256'(r1));
    checkOutput("stall_ctrl1", 256'(ctrlRegs), 256'(packCtrl()));
    checkOutput("stall_pulse1", 256'(ctrlWrPulse), 256'(p1));
    awaddr = 16'h0024; wdata = d2; awvalid = 1'b1; wvalid = 1'b1;
    checkOutput("stall_awready", 256'(awready), 256'(1'b1));
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("stall_held", 256'({awready, wready}), 256'(2'b00));
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_hold_bvalid", 256'(bvalid), 256'(1'b1));
      checkOutput("stall_hold_bresp", 256'(bresp), 256'(r1));
      checkOutput("stall_hold_pulse", 256'(ctrlWrPulse), 256'(0));
      @(negedge clk);
    end
    bready = 1'b1;
    modelWrite(16'h0024, d2, 4'hF, 3'b001, r2, p2);
    @(negedge clk);
    checkOutput("stall_bvalid2", 256'(bvalid), 256'(1'b1));
    checkOutput("stall_bresp2", 256'(bresp), 256'(r2));
    checkOutput("stall_ctrl2", 256'(ctrlRegs), 256'(packCtrl()));
    checkOutput("stall_pulse2", 256'(ctrlWrPulse), 256'(p2));
    @(negedge clk);
    checkOutput("stall_bvalid_drop", 256'(bvalid), 256'(1'b0));

    // R stall: response held stable while the status input changes
    @(negedge clk);
    araddr = 16'h002C; arprot = 3'b001; arvalid = 1'b1; rready = 1'b0;
    modelRead(16'h002C, 3'b001, expData, expResp, sp);
    @(negedge clk);
    arvalid = 1'b0;
    checkOutput("rstall_rvalid", 256'(rvalid), 256'(1'b1));
    checkOutput("rstall_pulse", 256'(statRdPulse), 256'(sp));
    statModel[3] = ~expData;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rstall_hold_rvalid", 256'(rvalid), 256'(1'b1));
      checkOutput("rstall_hold_rdata", 256'(rdata), 256'(expData));
      checkOutput("rstall_hold_rresp", 256'(rresp), 256'(expResp));
      checkOutput("rstall_arready", 256'(arready), 256'(1'b0));
    end
    rready = 1'b1;
    @(negedge clk);
    checkOutput("rstall_rvalid_drop", 256'(rvalid), 256'(1'b0));

    // Back-to-back reads with rready held high
    prevData = '0; prevResp = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checkOutput("b2b_rvalid", 256'(rvalid), 256'(1'b1));
        checkOutput("b2b_rdata", 256'(rdata), 256'(prevData));
        checkOutput("b2b_rresp", 256'(rresp), 256'(prevResp));
      end
      araddr = 16'($urandom_range(0, 13) * 4); arprot = 3'b001; arvalid = 1'b1;
      modelRead(araddr, 3'b001, prevData, prevResp, sp);
    end
    @(negedge clk);
    arvalid = 1'b0;
    checkOutput("b2b_last_rdata", 256'(rdata), 256'(prevData));
    checkOutput("b2b_last_rresp", 256'(rresp), 256'(prevResp));
    @(negedge clk);
    checkOutput("b2b_rvalid_drop", 256'(rvalid), 256'(1'b0));

    // Read sampled at the same edge as a write commit sees the old value
    d1 = ~ctrlModel[2];
    @(negedge clk);
    awaddr = 16'h0008; awprot = 3'b001; awvalid = 1'b1;
    wdata = d1; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 16'h0008; arprot = 3'b001; arvalid = 1'b1; rready = 1'b1;
    modelRead(16'h0008, 3'b001, expData, expResp, sp);
    modelWrite(16'h0008, d1, 4'hF, 3'b001, r1, p1);
    @(negedge clk);
    arvalid = 1'b0;
    checkOutput("same_rdata_old", 256'(rdata), 256'(expData));
    checkOutput("same_bvalid", 256'(bvalid), 256'(1'b1));
    checkOutput("same_ctrl_new", 256'(ctrlRegs), 256'(packCtrl()));
    @(negedge clk);

    // Reset while AW is held and R is pending
    doWrite(16'h0014, 32'hCAFEF00D, 4'hF, 3'b001);
    @(negedge clk);
    awaddr = 16'h0000; awprot = 3'b001; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    araddr = 16'h0014; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    checkOutput("prerst_rvalid", 256'(rvalid), 256'(1'b1));
    checkOutput("prerst_awready", 256'(awready), 256'(1'b0));
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < RC; i++) ctrlModel[i] = '0;
    checkOutput("midrst_valids", 256'({bvalid, rvalid}), 256'(2'b00));
    checkOutput("midrst_awready", 256'(awready), 256'(1'b1));
    checkOutput("midrst_ctrl", 256'(ctrlRegs), 256'(packCtrl()));
    @(negedge clk);
    rst_n = 1'b1; rready = 1'b1;
    @(negedge clk);
    d2 = $urandom;
    wdata = d2; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("postrst_no_commit", 256'(bvalid), 256'(1'b0));
      @(negedge clk);
    end
    awaddr = 16'h0018; awprot = 3'b001; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    modelWrite(16'h0018, d2, 4'hF, 3'b001, r1, p1);
    @(negedge clk);
    checkOutput("postrst_bvalid", 256'(bvalid), 256'(1'b1));
    checkOutput("postrst_bresp", 256'(bresp), 256'(r1));
    checkOutput("postrst_ctrl", 256'(ctrlRegs), 256'(packCtrl()));
    checkOutput("postrst_pulse", 256'(ctrlWrPulse), 256'(p1));
    @(negedge clk);

    // Unprivileged accesses (refused only when protection checking is built in)
    doWrite(16'h0000, 32'h0BADF00D, 4'hF, 3'b000);
    doRead(16'h0000, 3'b000);
    doRead(16'h0024, 3'b000);
    doRead(16'h0200, 3'b000);

    // Randomized traffic
    repeat (80) applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
